// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature measurement blocks.
//   state_e          : velocity-measurement FSM states (IDLE, BASE, RUN)
//   WINDOW_TICKS_DEF : default sample window, 1 ms at 32 MHz
//   LOG2_AVG_DEF     : default moving-average depth (2^LOG2_AVG windows)
package quad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BASE = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int WINDOW_TICKS_DEF = 32000;
  localparam int LOG2_AVG_DEF     = 2;

endpackage

// File: rtl/quad_tick_gen.sv
// Window tick generator.
//   clk, reset : system clock, async active-high reset
//   en         : run enable; while low the counter is held at 0
//   tick       : high in the cycle the counter sits at WINDOW_TICKS-1
module quad_tick_gen #(
  parameter int WINDOW_TICKS = quad_pkg::WINDOW_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(WINDOW_TICKS);
  localparam logic [CW-1:0] LAST = CW'(WINDOW_TICKS - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (!en || tick) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/quad_velocity.sv
// Quadrature velocity estimator: samples the position count once per window,
// forms the per-window delta and a 2^LOG2_AVG-window moving average.
//   clk, reset : system clock, async active-high reset
//   en         : measurement enable; low forces a full restart
//   count      : decoder position (unsigned, wraps mod 2^32)
//   velocity   : signed average counts/window (floor of sum / 2^LOG2_AVG)
//   delta      : signed counts in the most recent window
//   valid      : one-cycle strobe, velocity/delta updated
//   primed     : average window fully populated since restart
module quad_velocity
  import quad_pkg::*;
#(
  parameter int WINDOW_TICKS = WINDOW_TICKS_DEF,
  parameter int LOG2_AVG     = LOG2_AVG_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] count,
  output logic [31:0] velocity,
  output logic [31:0] delta,
  output logic        valid,
  output logic        primed
);

  localparam int DEPTH = 1 << LOG2_AVG;
  localparam int SW    = 32 + LOG2_AVG;   // sum of DEPTH 32-bit values cannot overflow
  localparam int FW    = LOG2_AVG + 1;

  state_e state, state_nxt;
  logic   tick_en, tick;

  logic        [31:0]            baseline;
  logic        [DEPTH-1:0][31:0] dbuf;    // dbuf[0] newest, dbuf[DEPTH-1] evicted next
  logic signed [SW-1:0]          sum, sum_nxt, avg;
  logic signed [31:0]            d, evicted;
  logic        [FW-1:0]          fill, fill_nxt;

  // Counter only runs once the FSM has left IDLE, so the first en-high
  // cycle is spent entering BASE and the window starts the cycle after.
  assign tick_en = en && (state != IDLE);

  quad_tick_gen #(.WINDOW_TICKS(WINDOW_TICKS)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    if (!en) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = BASE;
        BASE:    if (tick) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Modular subtraction reinterpreted as two's complement handles wrap.
  assign d        = count - baseline;
  assign evicted  = dbuf[DEPTH-1];
  assign sum_nxt  = sum + SW'(d) - SW'(evicted);
  assign avg      = sum_nxt >>> LOG2_AVG;
  assign fill_nxt = (fill == FW'(DEPTH)) ? fill : fill + FW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baseline <= '0;
      dbuf     <= '0;
      sum      <= '0;
      fill     <= '0;
      velocity <= '0;
      delta    <= '0;
      valid    <= 1'b0;
      primed   <= 1'b0;
    end else begin
      state <= state_nxt;
      valid <= 1'b0;
      if (!en || state == IDLE) begin
        dbuf   <= '0;
        sum    <= '0;
        fill   <= '0;
        primed <= 1'b0;
      end else if (tick) begin
        baseline <= count;
        if (state == RUN) begin
          for (int i = DEPTH - 1; i > 0; i--) dbuf[i] <= dbuf[i-1];
          dbuf[0]  <= d;
          sum      <= sum_nxt;
          fill     <= fill_nxt;
          primed   <= (fill_nxt == FW'(DEPTH));
          delta    <= d;
          velocity <= avg[31:0];
          valid    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_velocity.sv
// Bench for quad_velocity: two instances (LOG2_AVG=0 and 2) share stimulus.
module tb_quad_velocity;
  import quad_pkg::*;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset, en;
  logic [31:0] count;
  logic [31:0] vel0, del0, vel2, del2;
  logic        val0, val2, pr0, pr2;

  always #5 clk = ~clk;

  quad_velocity #(.WINDOW_TICKS(W), .LOG2_AVG(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .count(count),
    .velocity(vel0), .delta(del0), .valid(val0), .primed(pr0));

  quad_velocity #(.WINDOW_TICKS(W), .LOG2_AVG(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .count(count),
    .velocity(vel2), .delta(del2), .valid(val2), .primed(pr2));

  int checks = 0, errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // k = index of the current cycle within the present en-high run.
  // Samples land at k = W, 2W, ...; the first is only a baseline.
  int          k = -1;
  logic [31:0] base = '0;
  int          hist[$];
  logic        m_valid = 1'b0, m_pr0 = 1'b0, m_pr2 = 1'b0;
  logic [31:0] m_delta = '0, m_vel0 = '0, m_vel2 = '0;

  function automatic logic [31:0] avg_of(input int depth);
    longint s = 0, q;
    for (int i = 0; i < depth; i++)
      if (i < hist.size()) s += longint'(hist[hist.size()-1-i]);
    q = s / depth;
    if ((s % depth != 0) && (s < 0)) q -= 1;
    return 32'(q);
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [31:0] dd;
    if (reset) begin
      k = -1; base = '0; hist.delete();
      m_valid = 0; m_delta = '0; m_vel0 = '0; m_vel2 = '0; m_pr0 = 0; m_pr2 = 0;
    end else begin
      m_valid = 0;
      if (!en) begin
        k = -1; hist.delete(); m_pr0 = 0; m_pr2 = 0;
      end else begin
        k++;
        if (k >= W && (k % W) == 0) begin
          if (k == W) base = count;
          else begin
            dd = count - base;
            base = count;
            hist.push_back(int'($signed(dd)));
            m_valid = 1; m_delta = dd;
            m_vel0 = avg_of(1); m_vel2 = avg_of(4);
            m_pr0 = (hist.size() >= 1); m_pr2 = (hist.size() >= 4);
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic [31:0] obs_del[$], obs_v0[$], obs_v2[$], obs_p2[$];
  int first_valid = -1;

  always @(negedge clk) begin
    chk("valid0", 32'(val0), 32'(m_valid));
    chk("valid2", 32'(val2), 32'(m_valid));
    chk("delta0", del0, m_delta);
    chk("delta2", del2, m_delta);
    chk("vel0", vel0, m_vel0);
    chk("vel2", vel2, m_vel2);
    chk("primed0", 32'(pr0), 32'(m_pr0));
    chk("primed2", 32'(pr2), 32'(m_pr2));
    if (val2) begin
      obs_del.push_back(del2); obs_v0.push_back(vel0);
      obs_v2.push_back(vel2);  obs_p2.push_back(32'(pr2));
      if (first_valid < 0) first_valid = cyc;
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] vals[$], expq[$];
  int rise_cyc;

  task automatic chkq(input string nm, input logic [31:0] got[$], input logic [31:0] exp[$]);
    chk({nm, "_n"}, 32'(got.size()), 32'(exp.size()));
    foreach (exp[i]) chk(nm, (i < got.size()) ? got[i] : 32'hDEAD_BEEF, exp[i]);
  endtask

  // en rises in the current cycle; vals[m] is the count sampled at k=(m+1)*W.
  task automatic feed();
    obs_del.delete(); obs_v0.delete(); obs_v2.delete(); obs_p2.delete();
    first_valid = -1;
    en = 1'b1;
    rise_cyc = cyc;
    @(negedge clk);
    foreach (vals[i]) begin
      count = vals[i];
      repeat (W) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; count = '0;
    #1 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 32'(val2), 32'd0);
    chk("rst_vel", vel2, 32'd0);
    chk("rst_primed", 32'(pr2), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // deltas 4,4,4,4,8
    vals = '{32'd100, 32'd104, 32'd108, 32'd112, 32'd116, 32'd124};
    feed();
    chk("latency_a", 32'(first_valid - rise_cyc), 32'd17);
    expq = '{32'd4, 32'd4, 32'd4, 32'd4, 32'd8};  chkq("a_delta", obs_del, expq);
    chkq("a_vel0", obs_v0, expq);
    expq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};  chkq("a_vel2", obs_v2, expq);
    expq = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1};  chkq("a_primed2", obs_p2, expq);

    // drop en for one cycle exactly on a tick
    for (int i = 0; i < W && ((cyc - rise_cyc) % W) != 0; i++) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("held_vel2", vel2, 32'd5);
    chk("drop_primed2", 32'(pr2), 32'd0);

    // wrap-around both ways
    vals = '{32'hFFFF_FFF0, 32'h0000_0010, 32'hFFFF_FFF0};
    feed();
    chk("latency_b", 32'(first_valid - rise_cyc), 32'd17);
    expq = '{32'd32, 32'hFFFF_FFE0};  chkq("b_delta", obs_del, expq);
    expq = '{32'd8, 32'd0};           chkq("b_vel2", obs_v2, expq);

    // negative deltas, floor average
    en = 1'b0;
    repeat (3) @(negedge clk);
    vals = '{32'd50, 32'd49, 32'd48, 32'd47, 32'd46};
    feed();
    expq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    chkq("c_vel2", obs_v2, expq);
    expq = '{32'd0, 32'd0, 32'd0, 32'd1};  chkq("c_primed2", obs_p2, expq);

    // reset pulsed inside a valid cycle
    en = 1'b0;
    repeat (2) @(negedge clk);
    vals = '{32'd0};
    feed();
    count = 32'd5;
    begin
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(posedge clk); #1;
        if (val2) seen = 1;
      end
      chk("d_valid_seen", 32'(seen), 32'd1);
    end
    reset = 1'b1;
    #1;
    chk("d_valid", 32'(val2), 32'd0);
    chk("d_vel", vel2, 32'd0);
    chk("d_delta", del2, 32'd0);
    chk("d_primed0", 32'(pr0), 32'd0);
    chk("d_state", 32'(dut2.state), 32'(IDLE));
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_velocity.md
QUAD_VELOCITY -- requirements
Module: quad_velocity

Interface
REQ-001: Parameter WINDOW_TICKS, default 32000; sample window length in clk cycles, i.e. 1 ms at 32 MHz; legal range 2 to 2^24.
REQ-002: Parameter LOG2_AVG, default 2; moving-average depth is 2^LOG2_AVG windows; legal range 0 to 4.
REQ-003: clk  input  1  single system clock; all logic is in this one domain.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: en  input  1  measurement enable; level-sensitive.
REQ-006: count  input  32  position count from the quadrature decoder in the same clk domain; unsigned, wraps modulo 2^32.
REQ-007: velocity  output  32  signed, averaged counts per window.
REQ-008: delta  output  32  signed, raw counts in the most recent window.
REQ-009: valid  output  1  one-cycle strobe; velocity and delta were updated this cycle.
REQ-010: primed  output  1  high once 2^LOG2_AVG deltas have entered the average since the last restart.

Function
REQ-011: A tick counter SHALL run 0..WINDOW_TICKS-1 while en is high; tick is asserted in the cycle the counter equals WINDOW_TICKS-1, then the counter wraps to 0.
REQ-012: State machine states SHALL be IDLE, BASE and RUN.
REQ-013: IDLE: entered from reset, or from any state whenever en is low; the tick counter is held at 0; the delta buffer, running sum, fill count and primed are all cleared.
REQ-014: IDLE -> BASE SHALL occur in the first cycle en is high.
REQ-015: BASE: on tick, count SHALL be stored as the baseline and the state goes to RUN; no valid pulse is generated.
REQ-016: RUN: on each tick, d = count - baseline, taken modulo 2^32 and interpreted as two's-complement; baseline <= count.
REQ-017: In RUN, d SHALL be pushed into a 2^LOG2_AVG-entry circular buffer, and the oldest entry is evicted.
REQ-018: Running sum SHALL be 32+LOG2_AVG bits wide: sum <= sum + d - evicted, with no overflow possible.
REQ-019: velocity SHALL equal sum arithmetically right-shifted by LOG2_AVG (floor toward minus infinity).
REQ-020: delta and velocity SHALL be registered; valid is asserted exactly one cycle after the tick cycle, for exactly one cycle.
REQ-021: Buffer entries not yet written SHALL read as 0, so the average ramps up over the first 2^LOG2_AVG windows.
REQ-022: primed SHALL rise together with the valid of the 2^LOG2_AVG-th delta after entering RUN.
REQ-023: With LOG2_AVG=0, velocity SHALL equal delta, and primed rises with the first valid.
REQ-024: Wrap-around: a count going from 32'hFFFF_FFF0 to 32'h0000_0010 in one window SHALL give delta = +32; the reverse transition gives -32.
REQ-025: If en falls in a tick cycle, the tick SHALL be ignored and the state goes to IDLE.
REQ-026: velocity and delta SHALL hold their last values while in IDLE and BASE.
REQ-027: count changing in the tick cycle SHALL be sampled as its value on that clk edge; no extra synchronisation is added.

Reset
REQ-028: On reset assertion, all state SHALL clear asynchronously: state=IDLE, tick counter=0, baseline=0, buffer=0, sum=0, velocity=0, delta=0, valid=0, primed=0.
REQ-029: After reset deassertion, the first valid SHALL appear 2*WINDOW_TICKS+1 cycles after the first cycle with en high.
REQ-030: Reset asserted mid-window or mid-strobe SHALL abort immediately; no partial valid is emitted.

Structure
REQ-031: A shared package quad_pkg SHALL hold the state enum (IDLE, BASE, RUN) and the default WINDOW_TICKS/LOG2_AVG constants, so the quad decoder and related blocks reuse them.
REQ-032: The tick counter SHALL be a separate sub-module quad_tick_gen, with ports clk, reset, en, tick and parameter WINDOW_TICKS.
REQ-033: The buffer SHALL be registers, not inferred RAM; the target size is 120-400 RTL lines.

Verification
REQ-034: WINDOW_TICKS=8, LOG2_AVG=0, count +3 per window after priming -> valid every 8 cycles, delta=velocity=3, first valid 17 cycles after en rises.
REQ-035: LOG2_AVG=2, per-window deltas 4,4,4,4,8 -> velocity 1,2,3,4,5; primed rises with the 4th valid.
REQ-036: Baseline 32'hFFFF_FFF0, next sample 32'h0000_0010 -> delta=32; the reverse transition gives delta=-32 (32'hFFFF_FFE0).
REQ-037: Deltas -1,-1,-1,-1 with LOG2_AVG=2 -> velocity -1,-1,-1,-1 (arithmetic shift floor; the first three values are -1 because floor(-1/4), floor(-2/4), floor(-3/4) all equal -1).
REQ-038: en dropped for 1 cycle mid-RUN -> no valid in the next window; the next valid occurs 2*WINDOW_TICKS+1 cycles after en re-rises, primed cleared, velocity held in between.
REQ-039: reset pulsed during the valid cycle -> valid, velocity, delta and primed are 0 immediately, and the state is IDLE.
